// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S slave receiver.
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PAD   = 2'd3
  } rxState_e;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 24;

endpackage

// File: rtl/i2s_pin_sync.sv
// Synchronizer for one asynchronous I2S pin, with a registered level and
// a one-cycle rising-edge pulse that are aligned with each other.
module i2s_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;

  // level_o doubles as the previous synchronized sample for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      level_o <= 1'b0;
      rise_o  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], pin_i};
      level_o <= sync_q[STAGES-1];
      rise_o  <= sync_q[STAGES-1] & ~level_o;
    end
  end

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: captures MSB-first left/right words and presents them as a pair.
// Optional SCK-loss watchdog enabled by defining I2S_RX_TIMEOUT_EN.
module i2s_slave_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2s_sck_i,
  input  logic                  i2s_ws_i,
  input  logic                  i2s_sd_i,
  output logic [DATA_WIDTH-1:0] left_data_o,
  output logic [DATA_WIDTH-1:0] right_data_o,
  output logic                  frame_valid_o,
  output logic                  frame_err_o,
  output logic                  sck_lost_o
);

  localparam int            CW   = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] DW_C = CW'(DATA_WIDTH);

  logic sckRise, wsLevel, sdLevel;
  logic sckLevel_unused, wsRise_unused, sdRise_unused;

  rxState_e              state_q;
  logic [CW-1:0]         bitCnt_q;
  logic                  chan_q, wsPrev_q, primed_q, haveLeft_q;
  logic [DATA_WIDTH-1:0] shift_q, leftStage_q;

  logic [DATA_WIDTH-1:0] shiftNext_d, word_d;
  logic [CW-1:0]         bitsNow_d;
  logic                  wsChange_d, fullWord_d, latch_d, restart_d;

  i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk(clk), .reset(reset), .pin_i(i2s_sck_i), .level_o(sckLevel_unused), .rise_o(sckRise)
  );
  i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_ws_sync (
    .clk(clk), .reset(reset), .pin_i(i2s_ws_i), .level_o(wsLevel), .rise_o(wsRise_unused)
  );
  i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_sd_sync (
    .clk(clk), .reset(reset), .pin_i(i2s_sd_i), .level_o(sdLevel), .rise_o(sdRise_unused)
  );

`ifdef I2S_RX_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] idleCnt_q;
  logic          sckLost_q;
  assign sck_lost_o = sckLost_q;
`else
  assign sck_lost_o = 1'b0;
`endif

  // The WS-change edge carries the LSB of the word being closed, so a short
  // word still includes that edge's bit before zero-filling the rest.
  always_comb begin
    shiftNext_d = {shift_q[DATA_WIDTH-2:0], sdLevel};
    bitsNow_d   = bitCnt_q + 1'b1;
    wsChange_d  = wsLevel != wsPrev_q;
    fullWord_d  = bitsNow_d == DW_C;
    word_d      = fullWord_d ? shiftNext_d : (shiftNext_d << (DW_C - bitsNow_d));
    latch_d     = sckRise && (state_q == ST_SHIFT) && (fullWord_d || wsChange_d);
    restart_d   = sckRise && wsChange_d &&
                  (((state_q == ST_IDLE) && primed_q) || (state_q == ST_SHIFT) || (state_q == ST_PAD));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bitCnt_q      <= '0;
      chan_q        <= WS_LEFT;
      wsPrev_q      <= 1'b0;
      primed_q      <= 1'b0;
      haveLeft_q    <= 1'b0;
      shift_q       <= '0;
      leftStage_q   <= '0;
      left_data_o   <= '0;
      right_data_o  <= '0;
      frame_valid_o <= 1'b0;
      frame_err_o   <= 1'b0;
`ifdef I2S_RX_TIMEOUT_EN
      idleCnt_q     <= '0;
      sckLost_q     <= 1'b0;
`endif
    end else begin
      frame_valid_o <= 1'b0;
      frame_err_o   <= 1'b0;
      if (sckRise) wsPrev_q <= wsLevel;

      // wsPrev_q only means something once an edge has been seen since IDLE
      case (state_q)
        ST_IDLE:  if (sckRise) primed_q <= 1'b1;
        ST_SHIFT: begin
          if (sckRise && !wsChange_d) begin
            if (fullWord_d) begin
              state_q <= ST_PAD;
            end else begin
              shift_q  <= shiftNext_d;
              bitCnt_q <= bitsNow_d;
            end
          end
        end
        ST_PAD:   ;
        default: begin
          state_q    <= ST_IDLE;
          primed_q   <= 1'b0;
          haveLeft_q <= 1'b0;
        end
      endcase

      if (restart_d) begin
        state_q  <= ST_SHIFT;
        bitCnt_q <= '0;
        chan_q   <= wsLevel;
        shift_q  <= '0;
      end

      if (latch_d) begin
        if (!fullWord_d) frame_err_o <= 1'b1;
        if (chan_q == WS_LEFT) begin
          leftStage_q <= word_d;
          haveLeft_q  <= 1'b1;
        end else if (haveLeft_q) begin
          left_data_o   <= leftStage_q;
          right_data_o  <= word_d;
          frame_valid_o <= 1'b1;
        end
      end

`ifdef I2S_RX_TIMEOUT_EN
      if (sckRise) begin
        idleCnt_q <= '0;
        sckLost_q <= 1'b0;
      end else if (idleCnt_q != TO_LIMIT) begin
        idleCnt_q <= idleCnt_q + 1'b1;
        if (idleCnt_q == TO_LIMIT - 1'b1) begin
          sckLost_q  <= 1'b1;
          state_q    <= ST_IDLE;
          primed_q   <= 1'b0;
          haveLeft_q <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Randomized and directed bench for i2s_slave_rx, checked every cycle against a
// word-level model of the I2S stream (timeout checks only with I2S_RX_TIMEOUT_EN).
module tb_i2s_slave_rx;

  localparam int DW   = 24;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;
  localparam int TMO  = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sckPin = 1'b0, wsPin = 1'b0, sdPin = 1'b0;
  logic [DW-1:0] leftData, rightData;
  logic          frameValid, frameErr, sckLost;

  int passCount = 0, checkCount = 0, cyc = 0, validSeen = 0, errSeen = 0;

  bit            edgeWs[$];
  bit            edgeSd[$];
  bit            pendSd;
  int            evKind[int];
  logic [DW-1:0] evL[int], evR[int];
  int            expKind[int];
  logic [DW-1:0] expL[int], expR[int];
  logic [DW-1:0] curL = '0, curR = '0;

  i2s_slave_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .i2s_sck_i(sckPin), .i2s_ws_i(wsPin), .i2s_sd_i(sdPin),
    .left_data_o(leftData), .right_data_o(rightData), .frame_valid_o(frameValid),
    .frame_err_o(frameErr), .sck_lost_o(sckLost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bit carried on slot i (1-based) of a channel window; slots past the word are padding.
  function automatic bit slotBit(input logic [DW-1:0] v, input int i);
    if (i >= 1 && i <= DW) return v[DW-i];
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic newSegment();
    edgeWs.delete();
    edgeSd.delete();
    pendSd = 1'b0;
  endtask

  // One WS window of len SCK rising edges; its first edge carries the previous LSB.
  task automatic addWindow(input bit ch, input int len, input logic [DW-1:0] v);
    for (int k = 0; k < len; k++) begin
      edgeWs.push_back(ch);
      edgeSd.push_back(k == 0 ? pendSd : slotBit(v, k));
    end
    pendSd = slotBit(v, len);
  endtask

  // Word-level model: split the edge stream into WS windows and derive each word.
  function automatic void buildModel();
    int n = edgeWs.size();
    int start = 0;
    bit first = 1'b1;
    bit haveLeft = 1'b0;
    logic [DW-1:0] stage = '0;
    logic [DW-1:0] word;
    int len, bits, c, kind;
    evKind.delete();
    evL.delete();
    evR.delete();
    while (start < n) begin
      len = 1;
      while (start + len < n && edgeWs[start+len] == edgeWs[start]) len++;
      bits = (len < DW) ? len : DW;
      c = start + bits;
      if (!first && c < n) begin
        word = '0;
        for (int i = 1; i <= bits; i++) word = {word[DW-2:0], edgeSd[start+i]};
        word = word << (DW - bits);
        kind = (bits < DW) ? 2 : 0;
        if (edgeWs[start] == 1'b0) begin
          stage = word;
          haveLeft = 1'b1;
        end else if (haveLeft) begin
          kind |= 1;
          evL[c] = stage;
          evR[c] = word;
        end
        if (kind != 0) evKind[c] = kind;
      end
      first = 1'b0;
      start += len;
    end
  endfunction

  task automatic doReset();
    expKind.delete();
    expL.delete();
    expR.delete();
    reset = 1'b1;
    waitCycles(3);
    reset = 1'b0;
    waitCycles(2);
  endtask

  // SCK period is 8 clk; WS/SD change while SCK is low, as an I2S master drives them.
  task automatic applyStimulus();
    buildModel();
    for (int j = 0; j < edgeWs.size(); j++) begin
      wsPin  = edgeWs[j];
      sdPin  = edgeSd[j];
      sckPin = 1'b0;
      waitCycles(4);
      sckPin = 1'b1;
      if (evKind.exists(j)) begin
        expKind[cyc+LAT] = evKind[j];
        if (evL.exists(j)) begin
          expL[cyc+LAT] = evL[j];
          expR[cyc+LAT] = evR[j];
        end
      end
      waitCycles(4);
    end
    sckPin = 1'b0;
    waitCycles(LAT + 6);
  endtask

  always @(negedge clk) begin
    int kind;
    if (reset) begin
      curL = '0;
      curR = '0;
    end else begin
      kind = expKind.exists(cyc) ? expKind[cyc] : 0;
      if ((kind & 1) != 0) begin
        curL = expL[cyc];
        curR = expR[cyc];
      end
      if (frameValid) validSeen++;
      if (frameErr) errSeen++;
      checkOutput("frame_valid_o", 32'(frameValid), 32'((kind & 1) != 0));
      checkOutput("frame_err_o", 32'(frameErr), 32'((kind & 2) != 0));
      checkOutput("left_data_o", 32'(leftData), 32'(curL));
      checkOutput("right_data_o", 32'(rightData), 32'(curR));
`ifndef I2S_RX_TIMEOUT_EN
      checkOutput("sck_lost_o", 32'(sckLost), 32'd0);
`endif
    end
  end

  initial begin
    int baseV, baseE;
    bit ch;
    logic [DW-1:0] a, b, c, d;
    waitCycles(1);
    doReset();
    checkOutput("reset_left", 32'(leftData), 32'd0);
    checkOutput("reset_right", 32'(rightData), 32'd0);
    checkOutput("reset_valid", 32'(frameValid), 32'd0);

    // 24-slot windows
    newSegment();
    addWindow(1'b1, 24, DW'($urandom));
    addWindow(1'b0, 24, 24'h123456);
    addWindow(1'b1, 24, 24'hABCDEF);
    addWindow(1'b0, 24, DW'($urandom));
    baseV = validSeen;
    applyStimulus();
    checkOutput("w24_count", 32'(validSeen - baseV), 32'd1);
    checkOutput("w24_left", 32'(leftData), 32'h123456);
    checkOutput("w24_right", 32'(rightData), 32'hABCDEF);

    // 32-slot windows, trailing 8 bits ignored
    doReset();
    newSegment();
    addWindow(1'b1, 32, DW'($urandom));
    for (int f = 0; f < 3; f++) begin
      addWindow(1'b0, 32, 24'h123456);
      addWindow(1'b1, 32, 24'hABCDEF);
    end
    addWindow(1'b0, 4, DW'($urandom));
    baseV = validSeen;
    baseE = errSeen;
    applyStimulus();
    checkOutput("w32_count", 32'(validSeen - baseV), 32'd3);
    checkOutput("w32_err", 32'(errSeen - baseE), 32'd0);
    checkOutput("w32_left", 32'(leftData), 32'h123456);
    checkOutput("w32_right", 32'(rightData), 32'hABCDEF);

    // Short right word after 16 bits
    doReset();
    newSegment();
    addWindow(1'b1, 24, DW'($urandom));
    addWindow(1'b0, 24, 24'h123456);
    addWindow(1'b1, 16, 24'hFFFFFF);
    addWindow(1'b0, 24, DW'($urandom));
    addWindow(1'b1, 2, DW'($urandom));
    baseV = validSeen;
    baseE = errSeen;
    applyStimulus();
    checkOutput("short_err", 32'(errSeen - baseE), 32'd1);
    checkOutput("short_count", 32'(validSeen - baseV), 32'd1);
    checkOutput("short_right", 32'(rightData), 32'hFFFF00);
    checkOutput("short_left", 32'(leftData), 32'h123456);

    // Frame, then SCK halts mid-left word and reset hits
    doReset();
    newSegment();
    addWindow(1'b1, 24, DW'($urandom));
    addWindow(1'b0, 24, 24'h654321);
    addWindow(1'b1, 24, 24'h0FEDCB);
    addWindow(1'b0, 10, DW'($urandom));
    applyStimulus();
    checkOutput("pre_reset_left", 32'(leftData), 32'h654321);
    doReset();
    checkOutput("mid_reset_left", 32'(leftData), 32'd0);
    checkOutput("mid_reset_right", 32'(rightData), 32'd0);
    newSegment();
    addWindow(1'b0, 5, DW'($urandom));
    addWindow(1'b1, 24, DW'($urandom));
    addWindow(1'b0, 24, 24'h123456);
    addWindow(1'b1, 24, 24'hABCDEF);
    addWindow(1'b0, 3, DW'($urandom));
    baseV = validSeen;
    applyStimulus();
    checkOutput("post_reset_count", 32'(validSeen - baseV), 32'd1);
    checkOutput("post_reset_right", 32'(rightData), 32'hABCDEF);

    // Start mid-right word
    doReset();
    newSegment();
    a = DW'($urandom);
    b = DW'($urandom);
    c = DW'($urandom);
    d = DW'($urandom);
    addWindow(1'b1, 9, DW'($urandom));
    addWindow(1'b0, 24, a);
    addWindow(1'b1, 24, b);
    addWindow(1'b0, 24, c);
    addWindow(1'b1, 24, d);
    addWindow(1'b0, 3, DW'($urandom));
    baseV = validSeen;
    applyStimulus();
    checkOutput("midstart_count", 32'(validSeen - baseV), 32'd2);
    checkOutput("midstart_left", 32'(leftData), 32'(c));
    checkOutput("midstart_right", 32'(rightData), 32'(d));

    // Random window lengths, including short words
    for (int s = 0; s < 3; s++) begin
      doReset();
      newSegment();
      ch = 1'($urandom_range(0, 1));
      for (int w = 0; w < 14; w++) begin
        addWindow(ch, $urandom_range(10, 34), DW'($urandom));
        ch = !ch;
      end
      applyStimulus();
    end

`ifdef I2S_RX_TIMEOUT_EN
    doReset();
    newSegment();
    addWindow(1'b1, 24, DW'($urandom));
    addWindow(1'b0, 24, 24'h123456);
    addWindow(1'b1, 24, 24'hABCDEF);
    addWindow(1'b0, 2, DW'($urandom));
    applyStimulus();
    checkOutput("pre_timeout_lost", 32'(sckLost), 32'd0);
    waitCycles(TMO + 20);
    checkOutput("timeout_lost", 32'(sckLost), 32'd1);
    sckPin = 1'b1;
    waitCycles(LAT);
    checkOutput("resume_lost", 32'(sckLost), 32'd0);
    waitCycles(4);
    sckPin = 1'b0;
    waitCycles(8);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
